// File: rtl/basic_axi4_lite_master.sv
// AXI4-Lite initiator: one single-beat read or write in flight at a time, one-cycle result pulse.
// Latency: accept@0, request@1, response ready@2, result@3 at minimum; command held off while busy.
module basic_axi4_lite_master #(
    parameter int p_ADDRESS_WIDTH = 2,
    parameter int p_DATA_WIDTH    = 8,
    localparam int lp_STROBE_WIDTH = (p_DATA_WIDTH >= 8) ? p_DATA_WIDTH / 8 : 1
) (
    input  logic                       i_ACLK,
    input  logic                       i_ARESETN,
    input  logic                       i_CMD_VALID,
    output logic                       o_CMD_READY,
    input  logic                       i_CMD_WRITE,
    input  logic [p_ADDRESS_WIDTH-1:0] i_CMD_ADDR,
    input  logic [p_DATA_WIDTH-1:0]    i_CMD_WDATA,
    input  logic [lp_STROBE_WIDTH-1:0] i_CMD_WSTRB,
    input  logic                       i_CMD_PROT,
    output logic                       o_RSP_VALID,
    output logic                       o_RSP_WRITE,
    output logic [p_DATA_WIDTH-1:0]    o_RSP_RDATA,
    output logic [1:0]                 o_RSP_RESP,
    output logic [7:0]                 o_ERR_COUNT,
    output logic [p_ADDRESS_WIDTH-1:0] o_M_AWADDR,
    output logic                       o_M_AWPROT,
    output logic                       o_M_AWVALID,
    input  logic                       i_S_AWREADY,
    output logic [p_DATA_WIDTH-1:0]    o_M_WDATA,
    output logic [lp_STROBE_WIDTH-1:0] o_M_WSTRB,
    output logic                       o_M_WVALID,
    input  logic                       i_S_WREADY,
    input  logic [1:0]                 i_S_BRESP,
    input  logic                       i_S_BVALID,
    output logic                       o_M_BREADY,
    output logic [p_ADDRESS_WIDTH-1:0] o_M_ARADDR,
    output logic                       o_M_ARPROT,
    output logic                       o_M_ARVALID,
    input  logic                       i_S_ARREADY,
    input  logic [p_DATA_WIDTH-1:0]    i_S_RDATA,
    input  logic [1:0]                 i_S_RRESP,
    input  logic                       i_S_RVALID,
    output logic                       o_M_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP
    } state_t;

    state_t                       state_q;
    logic                         cmd_ready_q;
    logic                         awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                         rsp_valid_q, rsp_write_q;
    logic [p_ADDRESS_WIDTH-1:0]   awaddr_q, araddr_q;
    logic                         awprot_q, arprot_q;
    logic [p_DATA_WIDTH-1:0]      wdata_q, rsp_rdata_q;
    logic [lp_STROBE_WIDTH-1:0]   wstrb_q;
    logic [1:0]                   rsp_resp_q;
    logic [7:0]                   err_count_q;

    // A channel stays pending until its own VALID&READY; AW and W finish independently.
    logic       aw_pend_d, w_pend_d;
    logic       rsp_fire_d;
    logic [1:0] rsp_resp_d;

    assign aw_pend_d = awvalid_q & ~i_S_AWREADY;
    assign w_pend_d  = wvalid_q & ~i_S_WREADY;

    always_comb begin
        rsp_fire_d = 1'b0;
        rsp_resp_d = i_S_BRESP;
        if (state_q == S_WR_RESP && i_S_BVALID && bready_q) begin
            rsp_fire_d = 1'b1;
        end else if (state_q == S_RD_RESP && i_S_RVALID && rready_q) begin
            rsp_fire_d = 1'b1;
            rsp_resp_d = i_S_RRESP;
        end
    end

    always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
        if (!i_ARESETN) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            awprot_q    <= 1'b0;
            arprot_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            err_count_q <= 8'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (i_CMD_VALID && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (i_CMD_WRITE) begin
                            awaddr_q  <= i_CMD_ADDR;
                            awprot_q  <= i_CMD_PROT;
                            wdata_q   <= i_CMD_WDATA;
                            wstrb_q   <= i_CMD_WSTRB;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end else begin
                            araddr_q  <= i_CMD_ADDR;
                            arprot_q  <= i_CMD_PROT;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    awvalid_q <= aw_pend_d;
                    wvalid_q  <= w_pend_d;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (i_S_BVALID && bready_q) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= i_S_BRESP;
                        rsp_write_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (arvalid_q && i_S_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (i_S_RVALID && rready_q) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= i_S_RDATA;
                        rsp_resp_q  <= i_S_RRESP;
                        rsp_write_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Error counter saturates so a flood of errors never reads back as few.
            if (rsp_fire_d && rsp_resp_d != 2'b00 && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign o_CMD_READY = cmd_ready_q;
    assign o_RSP_VALID = rsp_valid_q;
    assign o_RSP_WRITE = rsp_write_q;
    assign o_RSP_RDATA = rsp_rdata_q;
    assign o_RSP_RESP  = rsp_resp_q;
    assign o_ERR_COUNT = err_count_q;
    assign o_M_AWADDR  = awaddr_q;
    assign o_M_AWPROT  = awprot_q;
    assign o_M_AWVALID = awvalid_q;
    assign o_M_WDATA   = wdata_q;
    assign o_M_WSTRB   = wstrb_q;
    assign o_M_WVALID  = wvalid_q;
    assign o_M_BREADY  = bready_q;
    assign o_M_ARADDR  = araddr_q;
    assign o_M_ARPROT  = arprot_q;
    assign o_M_ARVALID = arvalid_q;
    assign o_M_RREADY  = rready_q;

endmodule

// File: tb/tb_basic_axi4_lite_master.sv
// Bench for basic_axi4_lite_master: delay-programmable slave, response scoreboard, handshake stability monitor.
module tb_basic_axi4_lite_master;

    logic       i_ACLK, i_ARESETN;
    logic       i_CMD_VALID, o_CMD_READY, i_CMD_WRITE, i_CMD_PROT;
    logic [1:0] i_CMD_ADDR;
    logic [7:0] i_CMD_WDATA;
    logic [0:0] i_CMD_WSTRB;
    logic       o_RSP_VALID, o_RSP_WRITE;
    logic [7:0] o_RSP_RDATA, o_ERR_COUNT;
    logic [1:0] o_RSP_RESP;
    logic [1:0] o_M_AWADDR, o_M_ARADDR;
    logic       o_M_AWPROT, o_M_AWVALID, i_S_AWREADY;
    logic [7:0] o_M_WDATA;
    logic [0:0] o_M_WSTRB;
    logic       o_M_WVALID, i_S_WREADY;
    logic [1:0] i_S_BRESP, i_S_RRESP;
    logic       i_S_BVALID, o_M_BREADY;
    logic       o_M_ARPROT, o_M_ARVALID, i_S_ARREADY;
    logic [7:0] i_S_RDATA;
    logic       i_S_RVALID, o_M_RREADY;

    basic_axi4_lite_master dut (
        .i_ACLK(i_ACLK), .i_ARESETN(i_ARESETN),
        .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY), .i_CMD_WRITE(i_CMD_WRITE),
        .i_CMD_ADDR(i_CMD_ADDR), .i_CMD_WDATA(i_CMD_WDATA), .i_CMD_WSTRB(i_CMD_WSTRB),
        .i_CMD_PROT(i_CMD_PROT), .o_RSP_VALID(o_RSP_VALID), .o_RSP_WRITE(o_RSP_WRITE),
        .o_RSP_RDATA(o_RSP_RDATA), .o_RSP_RESP(o_RSP_RESP), .o_ERR_COUNT(o_ERR_COUNT),
        .o_M_AWADDR(o_M_AWADDR), .o_M_AWPROT(o_M_AWPROT), .o_M_AWVALID(o_M_AWVALID),
        .i_S_AWREADY(i_S_AWREADY), .o_M_WDATA(o_M_WDATA), .o_M_WSTRB(o_M_WSTRB),
        .o_M_WVALID(o_M_WVALID), .i_S_WREADY(i_S_WREADY), .i_S_BRESP(i_S_BRESP),
        .i_S_BVALID(i_S_BVALID), .o_M_BREADY(o_M_BREADY), .o_M_ARADDR(o_M_ARADDR),
        .o_M_ARPROT(o_M_ARPROT), .o_M_ARVALID(o_M_ARVALID), .i_S_ARREADY(i_S_ARREADY),
        .i_S_RDATA(i_S_RDATA), .i_S_RRESP(i_S_RRESP), .i_S_RVALID(i_S_RVALID),
        .o_M_RREADY(o_M_RREADY)
    );

    typedef struct {
        logic       write;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       strb;
        logic       prot;
        int         aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic       b_early;
        logic [1:0] bresp;
        logic [7:0] rdata;
        logic [1:0] rresp;
        logic [1:0] exp_resp;
        logic [7:0] exp_rdata;
        int         exp_lat;
        int         exp_err;
        int         acc_cyc;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   inflight = 0;
    int   err_model = 0;
    vec_t cur;
    vec_t exp_q[$];
    vec_t slv_q[$];

    initial begin
        i_ACLK = 1'b0;
        forever #5 i_ACLK = ~i_ACLK;
    end
    always @(posedge i_ACLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic vec_t mkv(input logic wr, input logic [1:0] a, input logic [7:0] wd,
                                 input logic st, input logic pr, input int awd, input int wdl,
                                 input int bd, input int ard, input int rd, input logic be,
                                 input logic [1:0] br, input logic [7:0] rdat, input logic [1:0] rr,
                                 input logic [1:0] er, input logic [7:0] erd, input int el, input int ee);
        vec_t v;
        v.write = wr; v.addr = a; v.wdata = wd; v.strb = st; v.prot = pr;
        v.aw_dly = awd; v.w_dly = wdl; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
        v.b_early = be; v.bresp = br; v.rdata = rdat; v.rresp = rr;
        v.exp_resp = er; v.exp_rdata = erd; v.exp_lat = el; v.exp_err = ee; v.acc_cyc = 0;
        return v;
    endfunction

    // Scoreboard and stability monitor, sampling just after the falling edge.
    vec_t       me;
    logic       prev_aw, prev_w, prev_ar;
    logic [1:0] p_awaddr, p_araddr;
    logic       p_awprot, p_arprot, p_wstrb;
    logic [7:0] p_wdata;
    always begin
        @(negedge i_ACLK);
        #1;
        if (!i_ARESETN) begin
            prev_aw = 1'b0; prev_w = 1'b0; prev_ar = 1'b0;
        end else begin
            if (o_RSP_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 32'(o_RSP_VALID), 32'd0);
                end else begin
                    me = exp_q.pop_front();
                    inflight--;
                    chk("rsp_write", 32'(o_RSP_WRITE), 32'(me.write));
                    chk("rsp_resp", 32'(o_RSP_RESP), 32'(me.exp_resp));
                    chk("rsp_rdata", 32'(o_RSP_RDATA), 32'(me.exp_rdata));
                    if (me.exp_lat >= 0) chk("latency", 32'(cyc - me.acc_cyc), 32'(me.exp_lat));
                    if (me.exp_resp != 2'b00 && err_model < 255) err_model++;
                    chk("err_count", 32'(o_ERR_COUNT), 32'(err_model));
                end
            end
            if (inflight > 0) chk("cmd_ready_busy", 32'(o_CMD_READY), 32'd0);
            if (prev_aw) chk("aw_hold", {29'd0, o_M_AWVALID, o_M_AWADDR}, {29'd0, 1'b1, p_awaddr});
            if (prev_aw) chk("awprot_hold", 32'(o_M_AWPROT), 32'(p_awprot));
            if (prev_w)  chk("w_hold", {22'd0, o_M_WVALID, o_M_WSTRB, o_M_WDATA}, {22'd0, 1'b1, p_wstrb, p_wdata});
            if (prev_ar) chk("ar_hold", {28'd0, o_M_ARVALID, o_M_ARPROT, o_M_ARADDR}, {28'd0, 1'b1, p_arprot, p_araddr});
            prev_aw = o_M_AWVALID && !i_S_AWREADY; p_awaddr = o_M_AWADDR; p_awprot = o_M_AWPROT;
            prev_w  = o_M_WVALID && !i_S_WREADY;   p_wdata = o_M_WDATA;   p_wstrb = o_M_WSTRB[0];
            prev_ar = o_M_ARVALID && !i_S_ARREADY; p_araddr = o_M_ARADDR; p_arprot = o_M_ARPROT;
            if (i_CMD_VALID && o_CMD_READY) begin
                me = cur;
                me.acc_cyc = cyc;
                exp_q.push_back(me);
                slv_q.push_back(me);
                inflight++;
            end
        end
    end

    // Slave: per transaction, READY/VALID delays taken from the accepted command's record.
    vec_t sc;
    bit   active, aw_done, w_done, hs_aw, hs_w, hs_b, hs_ar, hs_r;
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    initial begin
        i_S_AWREADY = 0; i_S_WREADY = 0; i_S_BVALID = 0; i_S_BRESP = 0;
        i_S_ARREADY = 0; i_S_RVALID = 0; i_S_RDATA = 0; i_S_RRESP = 0;
        active = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        forever begin
            @(negedge i_ACLK);
            if (!i_ARESETN) begin
                active = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                i_S_AWREADY = 0; i_S_WREADY = 0; i_S_BVALID = 0; i_S_ARREADY = 0; i_S_RVALID = 0;
            end else begin
                if (hs_aw) aw_done = 1;
                if (hs_w)  w_done = 1;
                if (hs_b || hs_r) begin active = 0; i_S_BVALID = 0; i_S_RVALID = 0; end
                hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                if (!active && (o_M_AWVALID || o_M_WVALID || o_M_ARVALID)) begin
                    if (slv_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                    else begin
                        sc = slv_q.pop_front(); active = 1; aw_done = 0; w_done = 0;
                        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                    end
                end
                i_S_AWREADY = 0; i_S_WREADY = 0; i_S_ARREADY = 0;
                if (active && sc.write) begin
                    if (o_M_AWVALID) begin chk("aw_repeat", 32'(aw_done), 32'd0); i_S_AWREADY = (aw_cnt >= sc.aw_dly); aw_cnt++; end
                    if (o_M_WVALID)  begin chk("w_repeat", 32'(w_done), 32'd0);   i_S_WREADY = (w_cnt >= sc.w_dly);   w_cnt++;  end
                    if (o_M_BREADY)  chk("bready_early", 32'(aw_done && w_done), 32'd1);
                    if (!i_S_BVALID) begin
                        if (sc.b_early) i_S_BVALID = 1;
                        else if (o_M_BREADY) begin i_S_BVALID = (b_cnt >= sc.b_dly); b_cnt++; end
                    end
                    i_S_BRESP = sc.bresp;
                    hs_aw = o_M_AWVALID && i_S_AWREADY;
                    hs_w  = o_M_WVALID && i_S_WREADY;
                    hs_b  = o_M_BREADY && i_S_BVALID;
                    if (hs_aw) chk("awaddr", {29'd0, o_M_AWPROT, o_M_AWADDR}, {29'd0, sc.prot, sc.addr});
                    if (hs_w)  chk("wdata", {23'd0, o_M_WSTRB, o_M_WDATA}, {23'd0, sc.strb, sc.wdata});
                end else if (active) begin
                    if (o_M_ARVALID) begin i_S_ARREADY = (ar_cnt >= sc.ar_dly); ar_cnt++; end
                    if (!i_S_RVALID && o_M_RREADY) begin i_S_RVALID = (r_cnt >= sc.r_dly); r_cnt++; end
                    i_S_RDATA = sc.rdata; i_S_RRESP = sc.rresp;
                    hs_ar = o_M_ARVALID && i_S_ARREADY;
                    hs_r  = o_M_RREADY && i_S_RVALID;
                    if (hs_ar) chk("araddr", {29'd0, o_M_ARPROT, o_M_ARADDR}, {29'd0, sc.prot, sc.addr});
                end
            end
        end
    end

    task automatic do_cmd(input vec_t c, input bit hold, output logic rv_at_acc);
        int n;
        n = 0;
        @(negedge i_ACLK);
        cur = c;
        i_CMD_WRITE = c.write; i_CMD_ADDR = c.addr; i_CMD_WDATA = c.wdata;
        i_CMD_WSTRB = c.strb;  i_CMD_PROT = c.prot; i_CMD_VALID = 1'b1;
        #2;
        while (!o_CMD_READY && n < 300) begin @(negedge i_ACLK); #2; n++; end
        if (!o_CMD_READY) begin
            chk("accept_timeout", 32'd0, 32'd1);
            i_CMD_VALID = 1'b0;
            rv_at_acc = 1'b0;
            return;
        end
        rv_at_acc = o_RSP_VALID;
        @(posedge i_ACLK);
        #1;
        if (!hold) i_CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((inflight > 0 || exp_q.size() > 0) && n < 500) begin @(posedge i_ACLK); n++; end
        if (n >= 500) chk("rsp_timeout", 32'(inflight), 32'd0);
        @(negedge i_ACLK);
        #2;
    endtask

    vec_t tbl[7];
    vec_t v;
    logic rv;
    logic [7:0] gen_last;
    int mx;

    initial begin
        i_ARESETN = 1'b1; i_CMD_VALID = 0; i_CMD_WRITE = 0; i_CMD_ADDR = 0;
        i_CMD_WDATA = 0; i_CMD_WSTRB = 0; i_CMD_PROT = 0;
        //            wr  ad  wdata  st pr aw w  b  ar r  early bresp rdata  rresp eresp erdata lat err
        tbl[0] = mkv(1, 2, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3, 0);
        tbl[1] = mkv(1, 1, 8'h3C, 1, 0, 0, 3, 0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 6, 0);
        tbl[2] = mkv(0, 2, 8'h00, 0, 0, 0, 0, 0, 0, 3, 0, 2'b00, 8'hA5, 2'b00, 2'b00, 8'hA5, 6, 0);
        tbl[3] = mkv(1, 3, 8'h77, 1, 0, 0, 2, 0, 0, 0, 1, 2'b10, 8'h00, 2'b00, 2'b10, 8'hA5, 5, 1);
        tbl[4] = mkv(0, 1, 8'h00, 0, 1, 0, 0, 0, 2, 0, 0, 2'b00, 8'h5A, 2'b11, 2'b11, 8'h5A, 5, 2);
        tbl[5] = mkv(1, 0, 8'hFF, 0, 1, 4, 1, 2, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00, 8'h5A, 9, 2);
        tbl[6] = mkv(0, 3, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'hC3, 2'b01, 2'b01, 8'hC3, 3, 3);

        #1 i_ARESETN = 1'b0;
        #3;
        chk("rst_cmd_ready", 32'(o_CMD_READY), 32'd0);
        chk("rst_valids", {27'd0, o_M_AWVALID, o_M_WVALID, o_M_BREADY, o_M_ARVALID, o_M_RREADY}, 32'd0);
        chk("rst_rsp", {20'd0, o_RSP_VALID, o_RSP_WRITE, o_RSP_RESP, o_RSP_RDATA}, 32'd0);
        chk("rst_err", 32'(o_ERR_COUNT), 32'd0);
        chk("rst_addr_data", {20'd0, o_M_AWADDR, o_M_ARADDR, o_M_WDATA}, 32'd0);
        repeat (2) @(negedge i_ACLK);
        i_ARESETN = 1'b1;
        #2 chk("ready_before_edge", 32'(o_CMD_READY), 32'd0);
        @(negedge i_ACLK);
        #2 chk("ready_after_release", 32'(o_CMD_READY), 32'd1);

        for (int i = 0; i < 7; i++) begin
            do_cmd(tbl[i], 1'b0, rv);
            wait_idle();
            chk("tbl_err_count", 32'(o_ERR_COUNT), 32'(tbl[i].exp_err));
        end

        v = mkv(1, 2, 8'h11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 8'h00, 2'b00, 2'b10, 8'hC3, 3, -1);
        for (int i = 0; i < 256; i++) begin
            do_cmd(v, 1'b0, rv);
            wait_idle();
        end
        chk("err_saturated", 32'(o_ERR_COUNT), 32'd255);

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) v = mkv(1, 2'(i), 8'(8'h40 + i), 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 2'b00, 2'b00,
                                    (i == 0) ? 8'hC3 : 8'h11, 3, -1);
            else            v = mkv(0, 2'(i), 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'(8'h11 * i), 2'b00, 2'b00,
                                    8'(8'h11 * i), 3, -1);
            do_cmd(v, (i < 3), rv);
            if (i > 0) chk("b2b_accept_in_rsp", 32'(rv), 32'd1);
        end
        wait_idle();

        v = mkv(0, 1, 8'h00, 0, 0, 0, 0, 0, 10, 0, 0, 2'b00, 8'h99, 2'b00, 2'b00, 8'h99, -1, -1);
        do_cmd(v, 1'b0, rv);
        repeat (2) @(posedge i_ACLK);
        #2 chk("arvalid_before_rst", 32'(o_M_ARVALID), 32'd1);
        i_ARESETN = 1'b0;
        #1;
        chk("rst_mid_valids", {28'd0, o_M_ARVALID, o_M_RREADY, o_CMD_READY, o_RSP_VALID}, 32'd0);
        exp_q.delete(); slv_q.delete(); inflight = 0; err_model = 0;
        repeat (2) @(negedge i_ACLK);
        i_ARESETN = 1'b1;
        @(negedge i_ACLK);
        #2;
        chk("ready_after_mid_rst", 32'(o_CMD_READY), 32'd1);
        chk("err_after_mid_rst", 32'(o_ERR_COUNT), 32'd0);
        do_cmd(tbl[0], 1'b0, rv);
        wait_idle();

        gen_last = 8'h00;
        for (int i = 0; i < 40; i++) begin
            v = mkv($urandom_range(1, 0), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                    $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom), 2'($urandom),
                    8'($urandom), 2'($urandom), 2'b00, 8'h00, 0, -1);
            if (v.write) begin
                mx = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
                v.exp_resp = v.bresp; v.exp_rdata = gen_last;
                v.exp_lat = v.b_early ? 3 + mx : 3 + mx + v.b_dly;
            end else begin
                v.exp_resp = v.rresp; v.exp_rdata = v.rdata; gen_last = v.rdata;
                v.exp_lat = 3 + v.ar_dly + v.r_dly;
            end
            do_cmd(v, (i < 39) && ($urandom_range(1, 0) == 1), rv);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/basic_axi4_lite_master.md
Name: basic_axi4_lite_master

Overview:
AXI4-Lite master (initiator) that converts single-beat user read/write commands into AXI4-Lite transactions toward a slave.
- One transaction outstanding at a time.
- Result is returned as a one-cycle response pulse.
- Counts error (non-OKAY) responses.
- Sits between control logic (sequencer/CPU bridge) and AXI4-Lite register slaves.

Parameters:
p_ADDRESS_WIDTH, 2, width of AWADDR/ARADDR and command address.
p_DATA_WIDTH, 8, width of WDATA/RDATA and command data; lp_STROBE_WIDTH = (p_DATA_WIDTH >= 8) ? p_DATA_WIDTH/8 : 1.

Ports:
i_ACLK  in  1  clock, all logic on rising edge
i_ARESETN  in  1  reset, asynchronous, active-low
i_CMD_VALID  in  1  command present
o_CMD_READY  out  1  master idle, command accepted when VALID&READY
i_CMD_WRITE  in  1  1=write, 0=read
i_CMD_ADDR  in  p_ADDRESS_WIDTH  target address
i_CMD_WDATA  in  p_DATA_WIDTH  write data
i_CMD_WSTRB  in  lp_STROBE_WIDTH  write byte strobes
i_CMD_PROT  in  1  protection bit, copied to AWPROT/ARPROT
o_RSP_VALID  out  1  one-cycle pulse, transaction complete
o_RSP_WRITE  out  1  completed transaction was a write
o_RSP_RDATA  out  p_DATA_WIDTH  read data (holds last read value)
o_RSP_RESP  out  2  BRESP or RRESP of completed transaction
o_ERR_COUNT  out  8  saturating count of responses with RESP != 2'b00
o_M_AWADDR  out  p_ADDRESS_WIDTH;  o_M_AWPROT  out  1;  o_M_AWVALID  out  1;  i_S_AWREADY  in  1
o_M_WDATA  out  p_DATA_WIDTH;  o_M_WSTRB  out  lp_STROBE_WIDTH;  o_M_WVALID  out  1;  i_S_WREADY  in  1
i_S_BRESP  in  2;  i_S_BVALID  in  1;  o_M_BREADY  out  1
o_M_ARADDR  out  p_ADDRESS_WIDTH;  o_M_ARPROT  out  1;  o_M_ARVALID  out  1;  i_S_ARREADY  in  1
i_S_RDATA  in  p_DATA_WIDTH;  i_S_RRESP  in  2;  i_S_RVALID  in  1;  o_M_RREADY  out  1

Behaviour:
- Reset (i_ARESETN=0, asynchronous):
  - State goes to IDLE.
  - All VALID/READY outputs, o_RSP_VALID, o_CMD_READY and o_ERR_COUNT are 0.
  - o_RSP_RDATA and o_RSP_RESP are 0; o_RSP_WRITE is 0.
  - Address/data outputs are 0.
- First rising edge with reset released: o_CMD_READY goes 1.
- Reset mid-transaction: the transaction is abandoned with no response pulse, and all VALIDs drop immediately.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - o_CMD_READY=1.
  - On i_CMD_VALID&o_CMD_READY: latch ADDR/WDATA/WSTRB/PROT onto the AXI outputs and set o_CMD_READY=0.
  - Write: o_M_AWVALID=1 and o_M_WVALID=1 on the next cycle; go to WR_REQ.
  - Read: o_M_ARVALID=1 on the next cycle; go to RD_REQ.
- WR_REQ:
  - AW and W channels are tracked independently.
  - AWVALID clears on the edge where AWVALID&i_S_AWREADY; WVALID clears on the edge where WVALID&i_S_WREADY.
  - Either order, or the same cycle, is allowed.
  - On the edge where the last of the two handshakes completes: o_M_BREADY=1, go to WR_RESP.
  - READY asserted by the slave before VALID is ignored; a handshake counts only when both are high.
- WR_RESP:
  - On i_S_BVALID&o_M_BREADY: BREADY=0, o_RSP_RESP=i_S_BRESP, o_RSP_WRITE=1, o_RSP_VALID=1 for one cycle.
  - Go to IDLE; o_CMD_READY=1 in the same cycle as o_RSP_VALID.
  - BVALID seen before both AW and W complete is ignored, because BREADY is still 0.
- RD_REQ: on ARVALID&i_S_ARREADY: ARVALID=0, o_M_RREADY=1, go to RD_RESP.
- RD_RESP:
  - On i_S_RVALID&o_M_RREADY: RREADY=0, o_RSP_RDATA=i_S_RDATA, o_RSP_RESP=i_S_RRESP, o_RSP_WRITE=0, o_RSP_VALID=1 for one cycle.
  - Go to IDLE.
- Stability: while any VALID is high, its address/data/strobe/prot outputs are held constant, and the VALID never drops before its handshake.
- Command fields are sampled only at command acceptance; command changes afterwards have no effect.
- o_ERR_COUNT increments on each response pulse with RESP != 0 and saturates at 255 (no wrap).
- Minimum latency with an always-ready slave:
  - Write: accept@0, AW/W@1, BREADY@2, B handshake@2 if BVALID is high, RSP_VALID@3.
  - Read: accept@0, AR@1, RREADY@2, RSP_VALID@3.
- Back-to-back: a new command may be accepted in the same cycle that o_RSP_VALID is high.

Test Plan:
- Write to an always-ready slave: CMD write addr=2, data=8'hA5, strb=1 → AWADDR=2/WDATA=A5 valid at cycle 1, BREADY at 2, RSP_VALID=1, RSP_WRITE=1, RESP=0 at cycle 3.
- Skewed write: AWREADY at cycle 1, WREADY held low until cycle 4 → WVALID and WDATA stay stable through cycle 4, BREADY rises only after cycle 4, exactly one RSP_VALID.
- Read after write: read addr=2 with slave returning RDATA=8'hA5, RRESP=0 after 3 stall cycles → RSP_RDATA=A5, RSP_WRITE=0, single-cycle pulse; o_CMD_READY=0 throughout.
- Early BVALID: slave asserts BVALID (BRESP=2'b10) before WREADY → ignored until W completes; then RSP_RESP=2'b10 and ERR_COUNT 0→1; 256 further SLVERR responses leave ERR_COUNT=255.
- Reset mid-read: drop i_ARESETN while ARVALID=1 → ARVALID, RREADY and CMD_READY go 0 asynchronously with no RSP_VALID; after release, CMD_READY=1 and a new write completes normally.
- Back-to-back: CMD_VALID held with alternating write/read → each new command is accepted in the RSP_VALID cycle of the previous one, for 4 commands and 4 responses in order.
